// File: rtl/wb_queue.sv
// Writeback queue: buffers ALU and load-unit results and drains them, in
// acceptance order, onto the regfile write port. Supports pending-write lookup.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      wen,
  output logic [ADDR_W-1:0]         writereg,
  output logic [DATA_W-1:0]         writedata,
  input  logic [ADDR_W-1:0]         query_reg,
  output logic                      query_hit,
  output logic [DATA_W-1:0]         query_data,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic              full, acc_mem, acc_alu, push, pop;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic [PTR_W-1:0]  q_idx;

  // Readies are held low while reset is asserted, independent of state.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign mem_ready = rst_n && !full;
  assign alu_ready = rst_n && !full && !mem_valid;
  assign acc_mem   = mem_valid && mem_ready;
  assign acc_alu   = alu_valid && alu_ready;
  assign in_rd     = acc_mem ? mem_rd : alu_rd;
  assign in_data   = acc_mem ? mem_data : alu_data;
  // Writes to x0 complete the handshake but are never stored.
  assign push      = (acc_mem || acc_alu) && (in_rd != '0);
  assign pop       = (count_q != '0);

  assign wen       = pop;
  assign writereg  = pop ? ent_rd_q[head_q] : '0;
  assign writedata = pop ? ent_data_q[head_q] : '0;
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PTR_W'(1);
    if (push) tail_d = tail_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Scan oldest to youngest so the last match is the youngest writer.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    q_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (query_reg != '0) && (ent_rd_q[q_idx] == query_reg)) begin
        query_hit  = 1'b1;
        query_data = ent_data_q[q_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[tail_q]   <= in_rd;
      ent_data_q[tail_q] <= in_data;
    end
  end
endmodule
